// File: rtl/ext_irq_requester.sv
// External interrupt requester: edge-detected device lines latched into pend/lost,
// masked onto ca_part_1, plus a period timer whose expiry feeds line 0.
module ext_irq_requester #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dev_req,
    input  logic        jisr,
    input  logic [15:0] mca_ext,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_sel,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    output logic [15:0] ca_part_1,
    output logic        irq_pending
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [15:0]        prev_q, pend_q, pend_d, mask_q, mask_d, lost_q, lost_d;
    logic               ten_q, ten_d, arl_q, arl_d;
    logic [CNT_W-1:0]   period_q, period_d, count_q, count_d;

    logic [CNT_W-1:0]   wd_per;
    logic [31:0]        period_rd, count_rd;
    logic               expire, wr_mask, wr_ctrl, wr_pend, wr_per, wr_lost;
    logic [15:0]        ev, clr;

    generate
        if (CNT_W < 32) begin : g_narrow
            assign wd_per    = cfg_wdata[CNT_W-1:0];
            assign period_rd = {{(32-CNT_W){1'b0}}, period_q};
            assign count_rd  = {{(32-CNT_W){1'b0}}, count_q};
        end else if (CNT_W == 32) begin : g_exact
            assign wd_per    = cfg_wdata;
            assign period_rd = period_q;
            assign count_rd  = count_q;
        end else begin : g_wide
            assign wd_per    = {{(CNT_W-32){1'b0}}, cfg_wdata};
            assign period_rd = period_q[31:0];
            assign count_rd  = count_q[31:0];
        end
    endgenerate

    assign wr_mask = cfg_we && (cfg_sel == 3'd0);
    assign wr_ctrl = cfg_we && (cfg_sel == 3'd1);
    assign wr_pend = cfg_we && (cfg_sel == 3'd2);
    assign wr_per  = cfg_we && (cfg_sel == 3'd3);
    assign wr_lost = cfg_we && (cfg_sel == 3'd4);

    assign expire = (state_q == RUN) && (count_q == period_q - CNT_W'(1));

    // Set beats clear: an event on a line always leaves pend set and never counts as lost
    // when that line is also being acknowledged or W1C-cleared.
    always_comb begin
        ev     = (dev_req & ~prev_q) | {15'b0, expire};
        clr    = (jisr ? mca_ext : 16'h0) | (wr_pend ? cfg_wdata[15:0] : 16'h0);
        pend_d = (pend_q & ~clr) | ev;
        lost_d = (lost_q & ~(wr_lost ? cfg_wdata[15:0] : 16'h0)) | (ev & pend_q & ~clr);
        mask_d = wr_mask ? cfg_wdata[15:0] : mask_q;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        ten_d    = wr_ctrl ? cfg_wdata[0] : ten_q;
        arl_d    = wr_ctrl ? cfg_wdata[1] : arl_q;
        period_d = wr_per  ? wd_per : period_q;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (ten_q && (period_q != '0)) state_d = RUN;
            end
            RUN: begin
                if ((wr_ctrl && !cfg_wdata[0]) || (wr_per && (wd_per == '0)) ||
                    !ten_q || (period_q == '0)) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (wr_per) begin
                    count_d = '0;
                end else if (expire) begin
                    count_d = '0;
                    if (!arl_q) begin
                        state_d = IDLE;
                        if (!wr_ctrl) ten_d = 1'b0;
                    end
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            prev_q   <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            lost_q   <= '0;
            ten_q    <= 1'b0;
            arl_q    <= 1'b0;
            period_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= dev_req;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            lost_q   <= lost_d;
            ten_q    <= ten_d;
            arl_q    <= arl_d;
            period_q <= period_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        cfg_rdata = 32'h0;
        case (cfg_sel)
            3'd0:    cfg_rdata = {16'h0, mask_q};
            3'd1:    cfg_rdata = {29'h0, (state_q == RUN), arl_q, ten_q};
            3'd2:    cfg_rdata = {16'h0, pend_q};
            3'd3:    cfg_rdata = period_rd;
            3'd4:    cfg_rdata = {16'h0, lost_q};
            3'd5:    cfg_rdata = count_rd;
            default: cfg_rdata = 32'h0;
        endcase
    end

    assign ca_part_1   = pend_q & mask_q;
    assign irq_pending = |ca_part_1;

endmodule

// File: tb/tb_ext_irq_requester.sv
// Directed vector bench for ext_irq_requester: each row's outputs are checked just
// before the clock edge that applies that row's inputs.
module tb_ext_irq_requester;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dev_req, mca_ext, ca_part_1;
    logic        jisr, cfg_we, irq_pending;
    logic [2:0]  cfg_sel;
    logic [31:0] cfg_wdata, cfg_rdata;

    ext_irq_requester #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .dev_req(dev_req), .jisr(jisr), .mca_ext(mca_ext),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .ca_part_1(ca_part_1), .irq_pending(irq_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] dev;
        logic        jisr;
        logic [15:0] mca;
        logic        we;
        logic [2:0]  sel;
        logic [31:0] wd;
        logic [15:0] ca;
        logic [31:0] rd;
    } vec_t;

    vec_t tv[0:127];
    int   nv = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic r, input logic [15:0] d, input logic j, input logic [15:0] m,
                       input logic w, input logic [2:0] s, input logic [31:0] wd,
                       input logic [15:0] ca, input logic [31:0] rd);
        tv[nv] = '{rst: r, dev: d, jisr: j, mca: m, we: w, sel: s, wd: wd, ca: ca, rd: rd};
        nv++;
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; dev_req = v.dev; jisr = v.jisr; mca_ext = v.mca;
        cfg_we = v.we; cfg_sel = v.sel; cfg_wdata = v.wd;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        // reset state
        add(1, 16'h0000, 0, 16'h0, 0, 3'd0, 32'h0,        16'h0000, 32'h0);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd1, 32'h0,        16'h0000, 32'h0);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd2, 32'h0,        16'h0000, 32'h0);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd3, 32'h0,        16'h0000, 32'h0);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd4, 32'h0,        16'h0000, 32'h0);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd5, 32'h0,        16'h0000, 32'h0);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd6, 32'h0,        16'h0000, 32'h0);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd7, 32'h0,        16'h0000, 32'h0);
        // mask line 2, pulse, acknowledge
        add(0, 16'h0000, 0, 16'h0,    1, 3'd0, 32'h4,     16'h0000, 32'h0);
        add(0, 16'h0004, 0, 16'h0,    0, 3'd0, 32'h0,     16'h0000, 32'h4);
        add(0, 16'h0000, 0, 16'h0,    0, 3'd2, 32'h0,     16'h0004, 32'h4);
        add(0, 16'h0000, 1, 16'h0004, 0, 3'd2, 32'h0,     16'h0004, 32'h4);
        add(0, 16'h0000, 0, 16'h0,    0, 3'd2, 32'h0,     16'h0000, 32'h0);
        // masked line 5 still latches, unmask exposes it
        add(0, 16'h0000, 0, 16'h0, 1, 3'd0, 32'h0,        16'h0000, 32'h4);
        add(0, 16'h0020, 0, 16'h0, 0, 3'd0, 32'h0,        16'h0000, 32'h0);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd2, 32'h0,        16'h0000, 32'h20);
        add(0, 16'h0000, 0, 16'h0, 1, 3'd0, 32'h20,       16'h0000, 32'h0);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd0, 32'h0,        16'h0020, 32'h20);
        add(0, 16'h0000, 0, 16'h0, 1, 3'd2, 32'h20,       16'h0020, 32'h20);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd2, 32'h0,        16'h0000, 32'h0);
        // lost on line 3; W1C with 0 has no effect; set beats ack
        add(0, 16'h0008, 0, 16'h0,    0, 3'd4, 32'h0,     16'h0000, 32'h0);
        add(0, 16'h0000, 0, 16'h0,    0, 3'd4, 32'h0,     16'h0000, 32'h0);
        add(0, 16'h0008, 0, 16'h0,    1, 3'd2, 32'h0,     16'h0000, 32'h8);
        add(0, 16'h0000, 0, 16'h0,    0, 3'd4, 32'h0,     16'h0000, 32'h8);
        add(0, 16'h0008, 1, 16'h0008, 0, 3'd2, 32'h0,     16'h0000, 32'h8);
        add(0, 16'h0000, 0, 16'h0,    0, 3'd2, 32'h0,     16'h0000, 32'h8);
        add(0, 16'h0000, 0, 16'h0,    0, 3'd4, 32'h0,     16'h0000, 32'h8);
        add(0, 16'h0000, 0, 16'h0,    1, 3'd4, 32'hFFFF,  16'h0000, 32'h8);
        add(0, 16'h0000, 0, 16'h0,    1, 3'd2, 32'hFFFF,  16'h0000, 32'h8);
        add(0, 16'h0000, 0, 16'h0,    0, 3'd4, 32'h0,     16'h0000, 32'h0);
        // timer period 4 auto-reload, then one-shot
        add(0, 16'h0000, 0, 16'h0, 1, 3'd0, 32'h1,        16'h0000, 32'h20);
        add(0, 16'h0000, 0, 16'h0, 1, 3'd3, 32'h4,        16'h0000, 32'h0);
        add(0, 16'h0000, 0, 16'h0, 1, 3'd1, 32'h3,        16'h0000, 32'h0);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd1, 32'h0,        16'h0000, 32'h3);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd5, 32'h0,        16'h0000, 32'h0);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd5, 32'h0,        16'h0000, 32'h1);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd5, 32'h0,        16'h0000, 32'h2);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd5, 32'h0,        16'h0000, 32'h3);
        add(0, 16'h0000, 0, 16'h0, 1, 3'd2, 32'h1,        16'h0001, 32'h1);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd5, 32'h0,        16'h0000, 32'h1);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd5, 32'h0,        16'h0000, 32'h2);
        add(0, 16'h0000, 0, 16'h0, 1, 3'd2, 32'h1,        16'h0000, 32'h0);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd2, 32'h0,        16'h0001, 32'h1);
        add(0, 16'h0000, 0, 16'h0, 1, 3'd1, 32'h1,        16'h0001, 32'h7);
        add(0, 16'h0000, 0, 16'h0, 1, 3'd2, 32'h1,        16'h0001, 32'h1);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd5, 32'h0,        16'h0000, 32'h3);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd1, 32'h0,        16'h0001, 32'h0);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd5, 32'h0,        16'h0001, 32'h0);
        // reset mid-RUN with every line pending; line held high through release
        add(0, 16'h0000, 0, 16'h0, 1, 3'd1, 32'h3,        16'h0001, 32'h0);
        add(0, 16'hFFFF, 0, 16'h0, 0, 3'd2, 32'h0,        16'h0001, 32'h1);
        add(0, 16'hFFFF, 0, 16'h0, 1, 3'd0, 32'hFFFF,     16'h0001, 32'h1);
        add(0, 16'hFFFF, 0, 16'h0, 0, 3'd2, 32'h0,        16'hFFFF, 32'hFFFF);
        add(0, 16'hFFFF, 0, 16'h0, 0, 3'd1, 32'h0,        16'hFFFF, 32'h7);
        add(1, 16'hFFFF, 0, 16'h0, 0, 3'd4, 32'h0,        16'hFFFF, 32'h1);
        add(0, 16'hFFFF, 0, 16'h0, 0, 3'd1, 32'h0,        16'h0000, 32'h0);
        add(0, 16'hFFFF, 0, 16'h0, 0, 3'd2, 32'h0,        16'h0000, 32'hFFFF);
        add(0, 16'hFFFF, 0, 16'h0, 0, 3'd3, 32'h0,        16'h0000, 32'h0);
        add(0, 16'hFFFF, 0, 16'h0, 0, 3'd5, 32'h0,        16'h0000, 32'h0);
        add(0, 16'hFFFF, 0, 16'h0, 0, 3'd0, 32'h0,        16'h0000, 32'h0);
        // period 1 auto-reload: expiry every cycle, then period rewrite and disable
        add(0, 16'h0000, 0, 16'h0, 1, 3'd2, 32'hFFFF,     16'h0000, 32'hFFFF);
        add(0, 16'h0000, 0, 16'h0, 1, 3'd3, 32'h1,        16'h0000, 32'h0);
        add(0, 16'h0000, 0, 16'h0, 1, 3'd1, 32'h3,        16'h0000, 32'h0);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd1, 32'h0,        16'h0000, 32'h3);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd2, 32'h0,        16'h0000, 32'h0);
        add(0, 16'h0000, 0, 16'h0, 1, 3'd2, 32'h1,        16'h0000, 32'h1);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd2, 32'h0,        16'h0000, 32'h1);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd4, 32'h0,        16'h0000, 32'h1);
        add(0, 16'h0000, 0, 16'h0, 1, 3'd3, 32'h3,        16'h0000, 32'h1);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd5, 32'h0,        16'h0000, 32'h0);
        add(0, 16'h0000, 0, 16'h0, 1, 3'd1, 32'h0,        16'h0000, 32'h7);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd5, 32'h0,        16'h0000, 32'h0);
        add(0, 16'h0000, 0, 16'h0, 0, 3'd1, 32'h0,        16'h0000, 32'h0);

        v = '{rst: 1, dev: 16'h0, jisr: 0, mca: 16'h0, we: 0, sel: 3'd0, wd: 32'h0, ca: 16'h0, rd: 32'h0};
        drive(v);
        repeat (2) @(negedge clk);

        for (int i = 0; i < nv; i++) begin
            @(negedge clk);
            drive(tv[i]);
            #1;
            chk($sformatf("row%0d ca_part_1", i), {16'h0, ca_part_1}, {16'h0, tv[i].ca});
            chk($sformatf("row%0d irq_pending", i), {31'h0, irq_pending}, {31'h0, (tv[i].ca != 16'h0)});
            chk($sformatf("row%0d cfg_rdata", i), cfg_rdata, tv[i].rd);
        end

        // reset wins over a same-cycle mask write
        @(negedge clk);
        rst = 1; cfg_we = 1; cfg_sel = 3'd0; cfg_wdata = 32'hFFFF; dev_req = 16'h0;
        @(negedge clk);
        rst = 0; cfg_we = 0; #1;
        chk("rst_over_write mask", cfg_rdata, 32'h0);

        // unused upper mask bits read 0; sel6 writes ignored
        @(negedge clk);
        cfg_we = 1; cfg_sel = 3'd0; cfg_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        cfg_we = 1; cfg_sel = 3'd6; cfg_wdata = 32'h0; #1;
        chk("sel6 read", cfg_rdata, 32'h0);
        @(negedge clk);
        cfg_we = 0; cfg_sel = 3'd0; #1;
        chk("mask upper bits", cfg_rdata, 32'h0000_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ext_irq_requester.md
EXT_IRQ_REQUESTER -- requirements
Module: ext_irq_requester

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the timer counter and of the period register.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port dev_req, input, 16 bits: device request lines, synchronous to clk, rising-edge triggered.
REQ-005 SHALL have port jisr, input, 1 bit: interrupt controller is taking an interrupt this cycle.
REQ-006 SHALL have port mca_ext, input, 16 bits: masked cause bits 22..7 from the controller, valid when jisr=1.
REQ-007 SHALL have port cfg_we, input, 1 bit: configuration write strobe.
REQ-008 SHALL have port cfg_sel, input, 3 bits: configuration register select.
REQ-009 SHALL have port cfg_wdata, input, 32 bits: configuration write data.
REQ-010 SHALL have port cfg_rdata, output, 32 bits: combinational read of the selected register.
REQ-011 SHALL have port ca_part_1, output, 16 bits: external cause bits, equal to pend & mask.
REQ-012 SHALL have port irq_pending, output, 1 bit: OR-reduction of ca_part_1.

Function
REQ-013 SHALL hold per-line registers: prev (last sample of dev_req), pend, mask, lost; all 16 bits.
REQ-014 SHALL raise the edge event for line i in cycle k when dev_req[i]=1 and prev[i]=0; pend[i] reads 1 after edge k (1-cycle latency to ca_part_1).
REQ-015 SHALL clear pend[i] on an edge where jisr=1 and mca_ext[i]=1.
REQ-016 SHALL clear pend[i] on a write with cfg_sel=2 and cfg_wdata[i]=1 (write-1-to-clear); writing 0 SHALL have no effect.
REQ-017 SHALL give set priority over clear: an event and a clear (ack or W1C) on the same line in the same cycle SHALL leave pend[i]=1 and lost[i] unchanged.
REQ-018 SHALL set lost[i] when an event arrives, pend[i]=1 already, and no clear for line i occurs that cycle.
REQ-019 SHALL, for line 0, OR the timer expiry event into the dev_req[0] edge event.
REQ-020 SHALL not gate pend with mask; masked lines still latch, and unmasking exposes them on ca_part_1 the next cycle.
REQ-021 SHALL use this register map (W = write when cfg_we=1):
  - sel0: mask[15:0], R/W.
  - sel1: ctrl, R/W: bit0 ten (timer enable), bit1 arl (auto-reload); bit2 reads 1 when the FSM is RUN (read-only).
  - sel2: pend, R; W1C as in REQ-016.
  - sel3: period[CNT_W-1:0], R/W.
  - sel4: lost, R/W1C.
  - sel5: count, R.
  - sel6, sel7: read 0, writes ignored.
  - Unused upper bits read 0.
REQ-022 SHALL implement a timer FSM with states IDLE and RUN.
REQ-023 SHALL, in IDLE, enter RUN with count=0 when ten=1 and period!=0.
REQ-024 SHALL, in RUN, increment count each cycle while count != period-1.
REQ-025 SHALL, in RUN with count == period-1, raise the expiry event and set count=0:
  - arl=1: stay in RUN.
  - arl=0: clear ten and enter IDLE.
REQ-026 SHALL go from RUN to IDLE with count=0 when ten is written 0 or period is written 0.
REQ-027 SHALL, on a write to sel3 while in RUN, set count=0 and continue in RUN with the new period (unless it is 0, per REQ-026).
REQ-028 SHALL make a cfg write take effect at the clock edge; reads SHALL show the new value in the following cycle.
REQ-029 SHALL, with period=1 and arl=1, raise an expiry event every cycle.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, clear prev, pend, mask, lost, ctrl, period and count, and put the FSM in IDLE.
REQ-031 SHALL hold ca_part_1=0, irq_pending=0 and cfg_rdata=0 (for every sel) after reset.
REQ-032 SHALL give rst priority over every event and write in the same cycle.
REQ-033 SHALL, if rst is applied while in RUN, discard any expiry due that cycle.
REQ-034 SHALL treat a dev_req line held high through reset release as an edge in the first cycle after reset, because prev=0.

Verification
REQ-035 Write mask=0x0004; pulse dev_req[2] -> next cycle ca_part_1=0x0004, irq_pending=1; jisr=1 with mca_ext=0x0004 -> next cycle ca_part_1=0.
REQ-036 With mask=0, pulse dev_req[5] -> ca_part_1=0, sel2 reads 0x0020; write mask=0x0020 -> next cycle ca_part_1=0x0020.
REQ-037 Pulse dev_req[3] twice without clearing -> sel4 reads 0x0008; edge on line 3 in the same cycle as jisr with mca_ext[3]=1 -> pend[3]=1, lost unchanged.
REQ-038 Set period=4, ctrl=0x3 -> pend[0] set every 4 cycles, count cycles 0,1,2,3; with ctrl=0x1 -> one expiry, then ctrl reads 0 and the FSM is IDLE.
REQ-039 Assert rst mid-RUN while pend=0xFFFF -> all registers read 0, ca_part_1=0, FSM IDLE.
REQ-040 Write sel2=0x0001 in the same cycle as a timer expiry -> pend[0] stays 1.
